// File: rtl/ibex_register_file_mp.sv
// ibex_register_file_mp: flop-based multi-port RISC-V integer register file
// with a per-register pending scoreboard used for issue/writeback hazard checks.
// Optional feature macro: IBEX_RF_BYPASS_EN enables same-cycle write-to-read
// forwarding. Without it, reads reflect stored state only.
module ibex_register_file_mp #(
  parameter bit RV32E      = 1'b0,
  parameter int DataWidth  = 32,
  parameter int NumRdPorts = 2,
  parameter int NumWrPorts = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumRdPorts*5-1:0]          raddr_i,
  output logic [NumRdPorts*DataWidth-1:0]  rdata_o,
  output logic [NumRdPorts-1:0]            rpend_o,
  input  logic [NumWrPorts*5-1:0]          waddr_i,
  input  logic [NumWrPorts*DataWidth-1:0]  wdata_i,
  input  logic [NumWrPorts-1:0]            we_i,
  input  logic                             issue_i,
  input  logic [4:0]                       issue_addr_i,
  input  logic                             flush_i
);

  // Architectural register count; addresses at or above it alias x0.
  localparam int NumRegs = RV32E ? 16 : 32;

  logic [DataWidth-1:0] rf_q [NumRegs];
  logic [DataWidth-1:0] rf_d [NumRegs];
  logic [NumRegs-1:0]   pend_q;
  logic [NumRegs-1:0]   pend_d;

  // Next register contents; ports scanned low to high so the youngest enabled writer wins.
  always_comb begin
    rf_d[0] = '0;
    for (int r = 1; r < NumRegs; r++) begin
      rf_d[r] = rf_q[r];
      for (int w = 0; w < NumWrPorts; w++) begin
        if (we_i[w] && (waddr_i[w*5+:5] == 5'(r))) begin
          rf_d[r] = wdata_i[w*DataWidth+:DataWidth];
        end
      end
    end
  end

  // Next pending state: flush clears, writebacks clear, then a new issue sets (youngest last).
  always_comb begin
    pend_d = pend_q;
    if (flush_i) begin
      pend_d = '0;
    end
    for (int r = 1; r < NumRegs; r++) begin
      for (int w = 0; w < NumWrPorts; w++) begin
        if (we_i[w] && (waddr_i[w*5+:5] == 5'(r))) begin
          pend_d[r] = 1'b0;
        end
      end
      if (issue_i && (issue_addr_i == 5'(r))) begin
        pend_d[r] = 1'b1;
      end
    end
    pend_d[0] = 1'b0;
  end

  // Combinational read ports; x0 and out-of-range addresses match no register and read 0.
  always_comb begin
    rdata_o = '0;
    rpend_o = '0;
    for (int p = 0; p < NumRdPorts; p++) begin
      for (int r = 1; r < NumRegs; r++) begin
        if (raddr_i[p*5+:5] == 5'(r)) begin
          rdata_o[p*DataWidth+:DataWidth] = rf_q[r];
          rpend_o[p]                      = pend_q[r];
`ifdef IBEX_RF_BYPASS_EN
          for (int w = 0; w < NumWrPorts; w++) begin
            if (we_i[w] && (waddr_i[w*5+:5] == 5'(r))) begin
              rdata_o[p*DataWidth+:DataWidth] = wdata_i[w*DataWidth+:DataWidth];
              rpend_o[p]                      = 1'b0;
            end
          end
`endif
        end
      end
    end
  end

  // State registers; reset clears data and scoreboard immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NumRegs; r++) begin
        rf_q[r] <= '0;
      end
      pend_q <= '0;
    end else begin
      rf_q   <= rf_d;
      pend_q <= pend_d;
    end
  end

endmodule
